// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the FFT datapath front end.
package fft_pkg;

  localparam int WIDTH      = 24;
  localparam int HALF_WIDTH = WIDTH / 2;

  typedef struct packed {
    logic signed [HALF_WIDTH-1:0] re;
    logic signed [HALF_WIDTH-1:0] im;
  } complex_t;

  // Real sample to complex word: real part is the sample, imaginary part is zero.
  function automatic complex_t pack_real(input logic signed [HALF_WIDTH-1:0] s);
    complex_t c;
    c.re = s;
    c.im = '0;
    return c;
  endfunction

  // Number of base-4 digits needed to index n points (floor of log4).
  function automatic int log4(input int n);
    int r;
    r = 0;
    for (int i = 1; i < 15; i++) begin
      if ((1 << (2 * i)) <= n) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_sample_loader_digit_rev4.sv
// Reverses the order of the base-4 digits of a group index.
module digit_rev4 #(
  parameter int DIGITS = 1
) (
  input  logic [2*DIGITS-1:0] g,
  output logic [2*DIGITS-1:0] rev
);

  // Digit i of the result is digit DIGITS-1-i of the input.
  always_comb begin
    rev = '0;
    for (int i = 0; i < DIGITS; i++) begin
      rev[2*i +: 2] = g[2*(DIGITS-1-i) +: 2];
    end
  end

endmodule

// File: rtl/fft_sample_loader.sv
// Ping-pong frame buffer that emits radix-4 digit-reversed groups of four
// packed complex words for the first butterfly stage.
module fft_sample_loader #(
  parameter int WIDTH    = 24,
  parameter int N_POINTS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [WIDTH/2-1:0]   sample_in,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  output logic [WIDTH-1:0]            a,
  output logic [WIDTH-1:0]            b,
  output logic [WIDTH-1:0]            c,
  output logic [WIDTH-1:0]            d,
  output logic                        group_valid,
  input  logic                        group_ready,
  output logic                        frame_first,
  output logic                        frame_last
);
  import fft_pkg::*;

  localparam int HALF  = WIDTH / 2;
  localparam int LOG4N = log4(N_POINTS);
  localparam int DIG   = LOG4N - 1;
  localparam int GW    = 2 * DIG;
  localparam int IW    = 2 * LOG4N;
  localparam int Q     = N_POINTS / 4;

  localparam logic [GW-1:0] LAST_G   = GW'(Q - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_POINTS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  if (N_POINTS < 16 || (1 << (2 * LOG4N)) != N_POINTS) begin : g_bad_n_points
    $error("fft_sample_loader: N_POINTS must be a power of 4 and at least 16");
  end

  function automatic logic [WIDTH-1:0] pack_word(input logic signed [HALF-1:0] s);
    return {s, {HALF{1'b0}}};
  endfunction

  logic signed [HALF-1:0] mem [2][N_POINTS];

  logic          wr_bank;
  logic          rd_bank;
  logic          wr_full;
  logic          wr_full_next;
  logic [IW-1:0] wr_idx;
  logic [0:0]    state;
  logic [GW-1:0] g;
  logic [GW-1:0] g_rev;

  logic in_hs;
  logic out_free;
  logic emit_load;
  logic read_done;
  logic swap;

  assign rd_bank   = ~wr_bank;
  assign in_hs     = sample_valid && sample_ready;
  assign out_free  = !group_valid || group_ready;
  assign emit_load = (state == EMIT) && out_free;
  assign read_done = emit_load && (g == LAST_G);
  // The read side frees its bank as soon as the last group is in the output
  // register, which lets the next frame start with no bubble.
  assign swap      = wr_full && ((state == IDLE) || read_done);

  digit_rev4 #(.DIGITS(DIG)) u_rev (
    .g   (g),
    .rev (g_rev)
  );

  // Next value of the write-bank full flag.
  always_comb begin
    wr_full_next = wr_full;
    if (swap)                              wr_full_next = 1'b0;
    else if (in_hs && wr_idx == LAST_IDX)  wr_full_next = 1'b1;
  end

  // Write side, bank swap and read FSM control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank      <= 1'b0;
      wr_full      <= 1'b0;
      wr_idx       <= '0;
      state        <= IDLE;
      g            <= '0;
      sample_ready <= 1'b0;
    end else begin
      sample_ready <= !wr_full_next;
      wr_full      <= wr_full_next;
      if (in_hs) wr_idx <= wr_idx + IW'(1);
      if (swap)  wr_bank <= ~wr_bank;
      if (swap) begin
        state <= EMIT;
        g     <= '0;
      end else if (read_done) begin
        state <= IDLE;
      end else if (emit_load) begin
        g <= g + GW'(1);
      end
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (in_hs) mem[wr_bank][wr_idx] <= sample_in;
  end

  // ---- output register stage: one group per accepted slot ----
  always_ff @(posedge clk) begin
    if (rst) begin
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      group_valid <= 1'b0;
      frame_first <= 1'b0;
      frame_last  <= 1'b0;
    end else if (emit_load) begin
      a           <= pack_word(mem[rd_bank][{2'd0, g_rev}]);
      b           <= pack_word(mem[rd_bank][{2'd1, g_rev}]);
      c           <= pack_word(mem[rd_bank][{2'd2, g_rev}]);
      d           <= pack_word(mem[rd_bank][{2'd3, g_rev}]);
      group_valid <= 1'b1;
      frame_first <= (g == '0);
      frame_last  <= (g == LAST_G);
    end else if (group_ready) begin
      group_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed self-checking bench for fft_sample_loader (N_POINTS 16 and 64).
module tb_fft_sample_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic signed [11:0] sample_in, sample_in64;
  logic               sample_valid, sample_valid64;
  logic               sample_ready, sample_ready64;
  logic [23:0]        a, b, c, d, a64, b64, c64, d64;
  logic               group_valid, group_ready, frame_first, frame_last;
  logic               group_valid64, group_ready64, frame_first64, frame_last64;

  fft_sample_loader #(.WIDTH(24), .N_POINTS(16)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .a(a), .b(b), .c(c), .d(d),
    .group_valid(group_valid), .group_ready(group_ready),
    .frame_first(frame_first), .frame_last(frame_last)
  );

  fft_sample_loader #(.WIDTH(24), .N_POINTS(64)) dut64 (
    .clk(clk), .rst(rst), .sample_in(sample_in64), .sample_valid(sample_valid64),
    .sample_ready(sample_ready64), .a(a64), .b(b64), .c(c64), .d(d64),
    .group_valid(group_valid64), .group_ready(group_ready64),
    .frame_first(frame_first64), .frame_last(frame_last64)
  );

  typedef struct {
    logic [23:0] a, b, c, d;
    logic        ff, fl;
    int          cyc;
  } grp_t;

  grp_t got_q[$];
  grp_t got64_q[$];
  grp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake; the handshake completes at the next edge.
  always @(negedge clk) begin
    if (!rst && group_valid && group_ready)
      got_q.push_back('{a, b, c, d, frame_first, frame_last, cyc});
    if (!rst && group_valid64 && group_ready64)
      got64_q.push_back('{a64, b64, c64, d64, frame_first64, frame_last64, cyc});
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [23:0] w(input int v);
    logic [11:0] t;
    t = 12'(v);
    return {t, 12'h000};
  endfunction

  task automatic send(input int sel, input int v);
    int n;
    n = 0;
    if (sel == 0) begin sample_in = 12'(v); sample_valid = 1'b1; end
    else begin sample_in64 = 12'(v); sample_valid64 = 1'b1; end
    forever begin
      @(negedge clk);
      if ((sel == 0) ? sample_ready : sample_ready64) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 64'(n), 64'(0));
        break;
      end
    end
    @(posedge clk); #1;
    sample_valid   = 1'b0;
    sample_valid64 = 1'b0;
  endtask

  task automatic send_frame(input int f[16]);
    for (int g = 0; g < 4; g++)
      exp_q.push_back('{w(f[g]), w(f[g+4]), w(f[g+8]), w(f[g+12]), g == 0, g == 3, 0});
    for (int i = 0; i < 16; i++) send(0, f[i]);
  endtask

  task automatic wait_groups(input int sel, input int cnt, input string tag);
    int have;
    have = 0;
    for (int i = 0; i < 400; i++) begin
      have = (sel == 0) ? got_q.size() : got64_q.size();
      if (have >= cnt) break;
      @(posedge clk);
    end
    @(posedge clk); #1;
    have = (sel == 0) ? got_q.size() : got64_q.size();
    chk({tag, "_count"}, 64'(have), 64'(cnt));
  endtask

  task automatic compare_q(input string tag);
    chk({tag, "_n"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_g%0d_a", tag, i), got_q[i].a, exp_q[i].a);
      chk($sformatf("%s_g%0d_b", tag, i), got_q[i].b, exp_q[i].b);
      chk($sformatf("%s_g%0d_c", tag, i), got_q[i].c, exp_q[i].c);
      chk($sformatf("%s_g%0d_d", tag, i), got_q[i].d, exp_q[i].d);
      chk($sformatf("%s_g%0d_flags", tag, i), {got_q[i].ff, got_q[i].fl},
          {exp_q[i].ff, exp_q[i].fl});
    end
  endtask

  initial begin
    int f[16];
    logic [23:0] sa, sd;
    logic        sff, sfl;

    rst = 1'b1;
    sample_in = '0; sample_valid = 1'b0; group_ready = 1'b1;
    sample_in64 = '0; sample_valid64 = 1'b0; group_ready64 = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", sample_ready, 0);
    chk("rst_gv", group_valid, 0);
    chk("rst_abcd", a | b | c | d, 0);
    chk("rst_flags", {frame_first, frame_last}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", sample_ready, 1);

    // Ramp 0,10..150 with latency check
    for (int i = 0; i < 16; i++) send(0, i * 10);
    chk("lat_e0", group_valid, 0);
    @(posedge clk); #1;
    chk("lat_e1", group_valid, 0);
    @(posedge clk); #1;
    chk("lat_e2", group_valid, 1);
    chk("lat_e2_first", frame_first, 1);
    wait_groups(0, 4, "ramp");
    chk("ramp_g0_a", got_q[0].a, 24'h000000);
    chk("ramp_g0_b", got_q[0].b, 24'h028000);
    chk("ramp_g0_c", got_q[0].c, 24'h050000);
    chk("ramp_g0_d", got_q[0].d, 24'h078000);
    chk("ramp_g0_ff", got_q[0].ff, 1);
    chk("ramp_g1_a", got_q[1].a, 24'h00A000);
    chk("ramp_g1_b", got_q[1].b, 24'h032000);
    chk("ramp_g1_c", got_q[1].c, 24'h05A000);
    chk("ramp_g1_d", got_q[1].d, 24'h082000);
    chk("ramp_g1_flags", {got_q[1].ff, got_q[1].fl}, 2'b00);
    chk("ramp_g3_a", got_q[3].a, 24'h01E000);
    chk("ramp_g3_b", got_q[3].b, 24'h046000);
    chk("ramp_g3_c", got_q[3].c, 24'h06E000);
    chk("ramp_g3_d", got_q[3].d, 24'h096000);
    chk("ramp_g3_fl", got_q[3].fl, 1);
    chk("ramp_burst", 64'(got_q[3].cyc - got_q[0].cyc), 64'(3));
    got_q.delete();

    // Negative sample sign preservation
    for (int i = 0; i < 16; i++) send(0, (i == 0) ? -100 : i);
    wait_groups(0, 4, "neg");
    chk("neg_re", got_q[0].a[23:12], 12'hF9C);
    chk("neg_im", got_q[0].a[11:0], 12'h000);
    chk("neg_b", got_q[0].b, 24'h004000);
    got_q.delete();

    // Backpressure mid-frame, then a full bank waiting on the swap
    group_ready = 1'b0;
    for (int i = 0; i < 16; i++) f[i] = 200 + i;
    send_frame(f);
    for (int i = 0; i < 20 && !group_valid; i++) begin @(posedge clk); #1; end
    chk("bp_gv", group_valid, 1);
    group_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    group_ready = 1'b0;
    for (int i = 0; i < 16; i++) f[i] = -50 * i;
    send_frame(f);
    sa = a; sd = d; sff = frame_first; sfl = frame_last;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_a_%0d", k), a, sa);
      chk($sformatf("bp_hold_d_%0d", k), d, sd);
      chk($sformatf("bp_hold_flags_%0d", k), {group_valid, frame_first, frame_last},
          {1'b1, sff, sfl});
      chk($sformatf("bp_ready_low_%0d", k), sample_ready, 0);
    end
    chk("bp_held_is_g2", sa, w(202));
    group_ready = 1'b1;
    for (int i = 0; i < 16; i++) f[i] = 1000 + 50 * i;
    send_frame(f);
    wait_groups(0, 12, "bp");
    compare_q("bp");
    got_q.delete(); exp_q.delete();

    // Three frames; the second is queued so it follows the first with no gap
    group_ready = 1'b0;
    for (int i = 0; i < 16; i++) f[i] = 11 * i;
    send_frame(f);
    for (int i = 0; i < 16; i++) f[i] = -13 * i;
    send_frame(f);
    group_ready = 1'b1;
    for (int i = 0; i < 16; i++) f[i] = 500 - 20 * i;
    send_frame(f);
    wait_groups(0, 12, "b2b");
    compare_q("b2b");
    chk("b2b_no_gap", 64'(got_q[4].cyc - got_q[3].cyc), 64'(1));
    chk("b2b_run8", 64'(got_q[7].cyc - got_q[0].cyc), 64'(7));
    got_q.delete(); exp_q.delete();

    // Reset with a held group and a partial frame
    group_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(0, 77 + i);
    for (int i = 0; i < 7; i++) send(0, 900 + i);
    chk("pre_rst_gv", group_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", sample_ready, 0);
    chk("mid_rst_gv", group_valid, 0);
    chk("mid_rst_abcd", a | b | c | d, 0);
    chk("mid_rst_flags", {frame_first, frame_last}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    group_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_stale", 64'(got_q.size()), 64'(0));
    for (int i = 0; i < 16; i++) f[i] = 5 - 3 * i;
    send_frame(f);
    wait_groups(0, 4, "rst");
    compare_q("rst");
    got_q.delete(); exp_q.delete();

    // 64-point digit reversal
    for (int i = 0; i < 64; i++) send(1, i);
    wait_groups(1, 16, "n64");
    chk("n64_g0_a", got64_q[0].a, 24'h000000);
    chk("n64_g0_b", got64_q[0].b, 24'h010000);
    chk("n64_g0_ff", got64_q[0].ff, 1);
    chk("n64_g1_a", got64_q[1].a, 24'h004000);
    chk("n64_g1_b", got64_q[1].b, 24'h014000);
    chk("n64_g1_c", got64_q[1].c, 24'h024000);
    chk("n64_g1_d", got64_q[1].d, 24'h034000);
    chk("n64_g4_a", got64_q[4].a, 24'h001000);
    chk("n64_g4_b", got64_q[4].b, 24'h011000);
    chk("n64_g4_c", got64_q[4].c, 24'h021000);
    chk("n64_g4_d", got64_q[4].d, 24'h031000);
    chk("n64_g15_a", got64_q[15].a, 24'h00F000);
    chk("n64_g15_d", got64_q[15].d, 24'h03F000);
    chk("n64_g15_flags", {got64_q[15].ff, got64_q[15].fl}, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_sample_loader.md
Name: fft_sample_loader

Overview:
Front end of the FFT datapath. It accepts a stream of real signed audio samples over a valid/ready handshake and buffers them in ping-pong frame banks. For each frame it transmits groups of four packed complex words (a, b, c, d) in radix-4 digit-reversed order, which is the input ordering the first butterfly_4 stage consumes. One bank fills while the other drains, so audio input is uninterrupted whenever the consumer keeps up.

Parameters:
WIDTH, 24, packed complex word width: real part in [WIDTH-1:HALF_WIDTH], imaginary part in [HALF_WIDTH-1:0].
N_POINTS, 16, frame length. Must be a power of 4 and at least 16; elaboration error otherwise.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
sample_in  input  WIDTH/2  signed real audio sample
sample_valid  input  1  sample_in is valid
sample_ready  output  1  loader can accept a sample
a, b, c, d  output  WIDTH  packed complex butterfly inputs, registered
group_valid  output  1  a..d hold a valid group
group_ready  input  1  downstream accepts the group
frame_first  output  1  high with the first group of a frame
frame_last  output  1  high with the last group of a frame

Behaviour:
- Reset (rst high at a clock edge):
  - sample_ready, group_valid, frame_first and frame_last go to 0; a..d go to 0.
  - Both banks are marked empty and write and read indices clear.
  - A reset mid-frame discards all buffered data, including a group held under backpressure.
  - sample_ready goes to 1 on the first edge after rst deasserts.
- Packing: each word is {sample, HALF_WIDTH'(0)}, i.e. real = sample and imag = 0. The sign is preserved with no scaling.
- Write side:
  - Each sample_valid && sample_ready handshake stores the sample at wr_idx in the write bank, then wr_idx increments.
  - The handshake at wr_idx = N_POINTS-1 marks the bank full and wraps wr_idx to 0.
- Swap:
  - Occurs when the write bank is full and the read side is IDLE, or when it is completing its last group handshake in the same cycle.
  - On swap the full bank becomes the read bank and the other bank becomes the write bank.
- Backpressure on input: if the write bank is full and no swap is possible, sample_ready is 0 until the swap edge. It returns to 1 on the edge after the swap. No sample is ever dropped or overwritten.
- Read FSM, two states:
  - IDLE -> EMIT on swap, with g = 0.
  - In EMIT, group g drives element k (k = 0..3, mapped to a..d) = bank[k*N_POINTS/4 + rev4(g)]. rev4 reverses the base-4 digits of g over log4(N_POINTS)-1 digits. For N_POINTS = 16, group g = {x[g], x[g+4], x[g+8], x[g+12]}.
  - On a group_valid && group_ready handshake, g increments. The handshake at g = N_POINTS/4-1 goes to IDLE, or stays in EMIT with g = 0 if a swap occurs the same cycle (back-to-back frames with no bubble).
- Output timing:
  - a..d, group_valid, frame_first and frame_last are registered.
  - The first group_valid rises 2 edges after the handshake of a frame's N_POINTS-th sample when the read side is idle: one edge to swap, one edge for the output register.
  - Afterwards, one group is presented per cycle while group_ready stays high.
- Hold rule: while group_valid && !group_ready, a..d, frame_first and frame_last stay stable.
- frame_first is high only for g = 0. frame_last is high only for g = N_POINTS/4-1.
- Storage: 2*N_POINTS registers of WIDTH/2 bits, allowing four simultaneous reads.

Decomposition:
- Shared package fft_pkg holds:
  - the WIDTH and HALF_WIDTH constants;
  - the complex_t packed typedef {re, im};
  - the pack_real() function;
  - the frame-length helper log4().
- Sub-module digit_rev4 (combinational, parameterized by digit count) computes rev4(g).
- Bank storage and both FSMs live in fft_sample_loader.

Test Plan:
- Feed samples 0,10,...,150, holding group_ready=1 -> group 0 is a={0,0}, b={40,0}, c={80,0}, d={120,0} with frame_first=1. Group 1 is {10,50,90,130}. Group 3 is {30,70,110,150} with frame_last=1. First group_valid appears 2 cycles after the 16th handshake.
- Feed sample -100 as x[0] -> a[23:12]=12'hF9C and a[11:0]=0.
- Hold group_ready=0 for 5 cycles mid-frame -> a..d stay stable. The following frame fills, then sample_ready=0 until the swap. No sample is lost, checked against a scoreboard.
- Stream 3 frames continuously with group_ready=1 -> the groups of frame 2 follow frame 1's frame_last with no idle cycle, and all 12 groups are correct.
- Assert rst after 7 samples, then send a full new frame -> only the new frame's data is emitted. All outputs read 0 during reset.
- With N_POINTS=64, feed ramp x[i]=i -> group 1 is {4,20,36,52} and group 4 is {1,17,33,49}.
